// File: rtl/mult_pkg.sv
// mult_pkg: constants and encodings shared by the Booth multiplier.
//   WIDTH  operand/result width (fixed by cla_32)
//   ITER   Booth iterations, one per multiplier bit
//   CNT_W  iteration counter width, wide enough to hold ITER
package mult_pkg;
  localparam int WIDTH = 32;
  localparam int ITER  = WIDTH;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_t;
endpackage

// File: rtl/cla_32.sv
// cla_32: 32-bit carry-lookahead adder.
//   a, b  addends
//   cin   carry in
//   sum   a + b + cin (mod 2^32)
// Eight 4-bit lookahead groups.
// Each group's carry-out is formed from its group generate/propagate
// terms and then rippled into the next group.
module cla_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);
  logic [31:0] g, p;
  logic [32:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int B = 4 * k;
    // carries inside the group, fully expanded from the group carry-in
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B])
                  | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
  end

  assign sum = p ^ c[31:0];
endmodule

// File: rtl/booth_mult_32.sv
// booth_mult_32: multi-cycle signed 32x32 radix-2 Booth multiplier.
//   clock       rising-edge clock
//   reset       asynchronous active-high reset
//   start       request pulse; accepted in IDLE or DONE
//   operand_a   multiplicand (signed)
//   operand_b   multiplier (signed)
//   result      low 32 bits of the product
//   exception   product does not fit in signed 32 bits
//   result_rdy  one-cycle pulse when result/exception are valid
//   busy        high while iterating
// Each of the 32 iterations does one add/sub/nop through a single cla_32.
// This is followed by an arithmetic right shift of the 65-bit {U,Q,q_1} register.
module booth_mult_32
  import mult_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_rdy,
  output logic             busy
);
  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] m;
  logic [2*WIDTH:0] p;

  booth_op_t        op;
  logic [WIDTH-1:0] u, y, s;
  logic             cin, ovf, sgn;
  logic [2*WIDTH:0] p_next;

  assign u = p[2*WIDTH:WIDTH+1];

  always_comb begin
    op = NOP;
    case (p[1:0])
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase
  end

  // NOP adds zero so the adder output is simply U and ovf stays 0.
  assign y   = (op == ADD) ? m : (op == SUB) ? ~m : '0;
  assign cin = (op == SUB);

  cla_32 u_cla (
    .a   (u),
    .b   (y),
    .cin (cin),
    .sum (s)
  );

  // S[31] is the wrong sign when the 32-bit add overflowed.
  // The shifted-in bit must carry the true sign, which handles -2^31 * -2^31.
  assign ovf    = (u[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != u[WIDTH-1]);
  assign sgn    = s[WIDTH-1] ^ ovf;
  assign p_next = {sgn, s, p[WIDTH:1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      m          <= '0;
      p          <= '0;
      result     <= '0;
      exception  <= 1'b0;
      result_rdy <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          result_rdy <= 1'b0;
          if (start) begin
            m     <= operand_a;
            p     <= {{WIDTH{1'b0}}, operand_b, 1'b0};
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          p     <= p_next;
          count <= count + 1'b1;
          if (count == CNT_W'(ITER - 1)) begin
            result     <= p_next[WIDTH:1];
            exception  <= (p_next[2*WIDTH:WIDTH+1] != {WIDTH{p_next[WIDTH]}});
            result_rdy <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          result_rdy <= 1'b0;
        end
      endcase
    end
  end
endmodule
